// File: rtl/perf_stats_tracker.sv
// Per-channel request/response performance counters with timestamp FIFOs for
// in-order latency matching, plus a free-running 64-bit cycle counter.
module perf_stats_tracker #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned LAT_W  = 16
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        clear,
   input  logic [NUM_CH-1:0]                           req_fire,
   input  logic [NUM_CH-1:0]                           req_rd,
   input  logic [NUM_CH-1:0]                           req_wr,
   input  logic [NUM_CH-1:0]                           resp_fire,
   input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
   output logic [63:0]                                 cycle_count,
   output logic [CNT_W-1:0]                            req_count,
   output logic [CNT_W-1:0]                            rd_count,
   output logic [CNT_W-1:0]                            wr_count,
   output logic [$clog2(DEPTH):0]                      outstanding,
   output logic [CNT_W-1:0]                            lat_sum,
   output logic [LAT_W-1:0]                            lat_max,
   output logic                                        ovf,
   output logic                                        unf
);

   localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned SUM_W = ((CNT_W > 32) ? CNT_W : 32) + 1;
   localparam int unsigned LX_W  = (LAT_W > 32) ? LAT_W : 32;

   logic [63:0]      cyc;
   logic [CNT_W-1:0] req_cnt [NUM_CH];
   logic [CNT_W-1:0] rd_cnt  [NUM_CH];
   logic [CNT_W-1:0] wr_cnt  [NUM_CH];
   logic [CNT_W-1:0] sum_q   [NUM_CH];
   logic [LAT_W-1:0] max_q   [NUM_CH];
   logic [NUM_CH-1:0] ovf_q, unf_q;
   logic [PTR_W-1:0] wptr [NUM_CH];
   logic [PTR_W-1:0] rptr [NUM_CH];
   logic [OCC_W-1:0] occ  [NUM_CH];
   logic [31:0]      mem  [NUM_CH][DEPTH];

   logic [NUM_CH-1:0] empty, full, push, pop, lat_vld, ovf_set, unf_set;
   logic [31:0]      lat     [NUM_CH];
   logic [SUM_W-1:0] sum_ext [NUM_CH];
   logic [LAT_W-1:0] lat_sat [NUM_CH];
   logic [CNT_W-1:0] sum_nxt [NUM_CH];
   logic [LAT_W-1:0] max_nxt [NUM_CH];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   // Per-channel event decode; an empty FIFO with req+resp is a zero-latency pass-through.
   always_comb begin
      empty   = '0;
      full    = '0;
      push    = '0;
      pop     = '0;
      lat_vld = '0;
      ovf_set = '0;
      unf_set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         lat[i]     = '0;
         sum_ext[i] = '0;
         lat_sat[i] = '0;
         sum_nxt[i] = sum_q[i];
         max_nxt[i] = max_q[i];
      end
      for (int i = 0; i < NUM_CH; i++) begin
         empty[i]   = (occ[i] == '0);
         full[i]    = (occ[i] == OCC_W'(DEPTH));
         pop[i]     = resp_fire[i] && !empty[i];
         push[i]    = req_fire[i] && !(empty[i] && resp_fire[i]) && (!full[i] || resp_fire[i]);
         lat_vld[i] = resp_fire[i] && (!empty[i] || req_fire[i]);
         ovf_set[i] = req_fire[i] && full[i] && !resp_fire[i];
         unf_set[i] = resp_fire[i] && empty[i] && !req_fire[i];
         if (pop[i]) begin
            lat[i] = cyc[31:0] - mem[i][rptr[i]];
         end
         sum_ext[i] = SUM_W'(sum_q[i]) + SUM_W'(lat[i]);
         lat_sat[i] = (LX_W'(lat[i]) > LX_W'({LAT_W{1'b1}})) ? '1 : LAT_W'(lat[i]);
         if (lat_vld[i]) begin
            sum_nxt[i] = (sum_ext[i] > SUM_W'({CNT_W{1'b1}})) ? '1 : CNT_W'(sum_ext[i]);
            max_nxt[i] = (lat_sat[i] > max_q[i]) ? lat_sat[i] : max_q[i];
         end
      end
   end

   // Statistics and FIFO pointer state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc   <= '0;
         ovf_q <= '0;
         unf_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            req_cnt[i] <= '0;
            rd_cnt[i]  <= '0;
            wr_cnt[i]  <= '0;
            sum_q[i]   <= '0;
            max_q[i]   <= '0;
            wptr[i]    <= '0;
            rptr[i]    <= '0;
            occ[i]     <= '0;
         end
      end else begin
         cyc <= cyc + 64'd1;
         for (int i = 0; i < NUM_CH; i++) begin
            if (clear) begin
               req_cnt[i] <= '0;
               rd_cnt[i]  <= '0;
               wr_cnt[i]  <= '0;
               sum_q[i]   <= '0;
               max_q[i]   <= '0;
               wptr[i]    <= '0;
               rptr[i]    <= '0;
               occ[i]     <= '0;
               ovf_q[i]   <= 1'b0;
               unf_q[i]   <= 1'b0;
            end else begin
               if (req_fire[i]) begin
                  req_cnt[i] <= sat_inc(req_cnt[i]);
                  if (req_rd[i]) rd_cnt[i] <= sat_inc(rd_cnt[i]);
                  if (req_wr[i]) wr_cnt[i] <= sat_inc(wr_cnt[i]);
               end
               if (push[i]) wptr[i] <= wptr[i] + PTR_W'(1);
               if (pop[i])  rptr[i] <= rptr[i] + PTR_W'(1);
               if (push[i] && !pop[i])      occ[i] <= occ[i] + OCC_W'(1);
               else if (pop[i] && !push[i]) occ[i] <= occ[i] - OCC_W'(1);
               sum_q[i] <= sum_nxt[i];
               max_q[i] <= max_nxt[i];
               ovf_q[i] <= ovf_q[i] | ovf_set[i];
               unf_q[i] <= unf_q[i] | unf_set[i];
            end
         end
      end
   end

   // Timestamp storage; stale entries are harmless because pointers gate every read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i]) mem[i][wptr[i]] <= cyc[31:0];
      end
   end

   assign cycle_count = cyc;

   // Readout mux; an unmatched select leaves everything at zero.
   always_comb begin
      req_count   = '0;
      rd_count    = '0;
      wr_count    = '0;
      outstanding = '0;
      lat_sum     = '0;
      lat_max     = '0;
      ovf         = 1'b0;
      unf         = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            req_count   = req_cnt[i];
            rd_count    = rd_cnt[i];
            wr_count    = wr_cnt[i];
            outstanding = occ[i];
            lat_sum     = sum_q[i];
            lat_max     = max_q[i];
            ovf         = ovf_q[i];
            unf         = unf_q[i];
         end
      end
   end

endmodule
